// File: rtl/if_stage_fetch_queue_if.sv
// Fetch-stage bus bundle: ID handshake, branch bus, instruction SRAM port and WB redirect.
// The fetch stage drives through the master modport; its environment uses slave.
interface if_stage_fetch_queue_if;
   logic        ds_allowin;
   logic [34:0] br_bus;
   logic        fs_to_ds_valid;
   logic [70:0] fs_to_ds_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        flush;
   logic [31:0] CP0_EPC;
   logic        ws_inst_eret;

   modport master (
      input  ds_allowin, br_bus, inst_sram_rdata, flush, CP0_EPC, ws_inst_eret,
      output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen,
             inst_sram_addr, inst_sram_wdata
   );

   modport slave (
      output ds_allowin, br_bus, inst_sram_rdata, flush, CP0_EPC, ws_inst_eret,
      input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen,
             inst_sram_addr, inst_sram_wdata
   );
endinterface

// File: rtl/if_stage_fetch_queue.sv
// IF stage with a DEPTH-entry fetch queue, branch delay-slot tracking and WB redirects.
// Optional macro FS_QUEUE_BYPASS_EN forwards an SRAM response straight to ID when the queue is empty.
module if_stage_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter logic [31:0] EXC_VEC  = 32'hbfc00380
) (
   input  logic                   clk,
   input  logic                   resetn,
   if_stage_fetch_queue_if.master fq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [4:0] EXC_ADEL = 5'h04;

   typedef enum logic [1:0] {S_RUN, S_BR_DS, S_HALT} state_t;

   state_t        r_state, w_state_next;
   logic [31:0]   r_fetch_pc, w_fetch_pc_next;
   logic [31:0]   r_br_target, w_br_target_next;
   logic [PW-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_next, w_wr_ptr_next;
   logic [CW-1:0] r_count, w_count_next;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;

   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_inst [DEPTH];
   logic          r_q_ex   [DEPTH];

   logic          w_ds_is_branch, w_br_stall, w_br_taken, w_br_stall_eff;
   logic [31:0]   w_br_target, w_redirect_pc, w_req_pc;
   logic          w_flush, w_q_empty, w_bypass, w_out_valid, w_pop, w_pop_q;
   logic          w_resp_push, w_ds_in_queue, w_ds_held, w_br_act, w_discard;
   logic          w_exc_push, w_push, w_credit, w_req;

   assign w_ds_is_branch = fq.br_bus[34];
   assign w_br_stall     = fq.br_bus[33];
   assign w_br_taken     = fq.br_bus[32];
   assign w_br_target    = fq.br_bus[31:0];
   assign w_flush        = fq.flush;
   assign w_br_stall_eff = w_br_stall && !w_flush;
   assign w_redirect_pc  = fq.ws_inst_eret ? fq.CP0_EPC : EXC_VEC;
   assign w_q_empty      = (r_count == '0);

`ifdef FS_QUEUE_BYPASS_EN
   assign w_bypass = !w_flush && w_q_empty && r_inflight;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_out_valid = !w_q_empty || w_bypass;
   assign w_pop       = w_out_valid && fq.ds_allowin;
   assign w_pop_q     = w_pop && !w_q_empty;
   assign w_resp_push = r_inflight && !(w_pop && w_bypass);

   // Delay slot is the oldest survivor: queue entry after this pop, else the arriving response.
   assign w_ds_in_queue = (r_count - CW'(w_pop_q)) != '0;
   assign w_ds_held     = w_ds_in_queue || w_resp_push;
   assign w_br_act      = w_br_taken && !w_flush && (r_state != S_HALT);
   assign w_discard     = w_br_act && w_ds_in_queue;

   assign w_exc_push = !w_flush && !w_br_act && (r_state != S_HALT) &&
                       (r_fetch_pc[1:0] != 2'b00) && !r_inflight && (r_count < CW'(DEPTH));
   assign w_push     = w_exc_push || (w_resp_push && !w_discard && !w_flush);

   assign w_req_pc = w_flush                 ? w_redirect_pc :
                     (w_br_act && w_ds_held) ? w_br_target   : r_fetch_pc;
   // Credit counts the outstanding response so a full queue can never be overrun.
   assign w_credit = w_flush || ((r_count + CW'(r_inflight)) < CW'(DEPTH));
   assign w_req    = resetn && (w_flush || (r_state != S_HALT)) && !w_br_stall_eff &&
                     w_credit && (w_req_pc[1:0] == 2'b00);

   assign fq.inst_sram_en    = w_req;
   assign fq.inst_sram_addr  = w_req_pc;
   assign fq.inst_sram_wen   = 4'h0;
   assign fq.inst_sram_wdata = 32'h0;

   always_comb begin
      fq.fs_to_ds_valid = w_out_valid;
      fq.fs_to_ds_bus   = '0;
      if (w_bypass) begin
         fq.fs_to_ds_bus = {1'b0, 5'h00, w_ds_is_branch, fq.inst_sram_rdata, r_inflight_pc};
      end else if (!w_q_empty) begin
         fq.fs_to_ds_bus = {r_q_ex[r_rd_ptr], r_q_ex[r_rd_ptr] ? EXC_ADEL : 5'h00,
                            w_ds_is_branch, r_q_inst[r_rd_ptr], r_q_pc[r_rd_ptr]};
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_fetch_pc_next  = r_fetch_pc;
      w_br_target_next = r_br_target;
      w_rd_ptr_next    = r_rd_ptr;
      w_wr_ptr_next    = r_wr_ptr;
      w_count_next     = r_count;
      if (w_flush) begin
         w_state_next    = S_RUN;
         w_rd_ptr_next   = '0;
         w_wr_ptr_next   = '0;
         w_count_next    = '0;
         w_fetch_pc_next = w_req ? w_req_pc + 32'd4 : w_req_pc;
      end else begin
         w_rd_ptr_next = r_rd_ptr + PW'(w_pop_q);
         if (w_discard) begin
            w_wr_ptr_next = w_rd_ptr_next + PW'(1);
            w_count_next  = CW'(1);
         end else begin
            w_wr_ptr_next = r_wr_ptr + PW'(w_push);
            w_count_next  = r_count + CW'(w_push) - CW'(w_pop_q);
         end
         if (w_br_act) begin
            w_state_next = S_RUN;
            if (w_ds_held) begin
               w_fetch_pc_next = w_req ? w_br_target + 32'd4 : w_br_target;
            end else if (w_req) begin
               w_fetch_pc_next = w_br_target;
            end else begin
               w_state_next     = S_BR_DS;
               w_br_target_next = w_br_target;
            end
         end else begin
            case (r_state)
               S_RUN: begin
                  if (w_req)           w_fetch_pc_next = r_fetch_pc + 32'd4;
                  else if (w_exc_push) w_state_next    = S_HALT;
               end
               S_BR_DS: begin
                  if (w_req) begin
                     w_fetch_pc_next = r_br_target;
                     w_state_next    = S_RUN;
                  end else if (w_exc_push) begin
                     w_state_next = S_HALT;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_RUN;
         r_fetch_pc    <= RESET_PC;
         r_br_target   <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_state       <= w_state_next;
         r_fetch_pc    <= w_fetch_pc_next;
         r_br_target   <= w_br_target_next;
         r_rd_ptr      <= w_rd_ptr_next;
         r_wr_ptr      <= w_wr_ptr_next;
         r_count       <= w_count_next;
         r_inflight    <= w_req;
         r_inflight_pc <= w_req_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_ex[r_wr_ptr]   <= w_exc_push;
         r_q_inst[r_wr_ptr] <= w_exc_push ? 32'h0 : fq.inst_sram_rdata;
         r_q_pc[r_wr_ptr]   <= w_exc_push ? r_fetch_pc : r_inflight_pc;
      end
   end
endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// Directed bench for if_stage_fetch_queue: sequential fetch, back-pressure, branches,
// misaligned target, flush and eret redirects; SRAM returns addr ^ KEY one cycle later.
module tb_if_stage_fetch_queue;
   localparam logic [31:0] KEY = 32'h13579bdf;
`ifdef FS_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [31:0] req_addr [$];
   int          req_cyc  [$];
   logic [70:0] dlv_bus  [$];
   int          dlv_cyc  [$];

   if_stage_fetch_queue_if fq();

   if_stage_fetch_queue dut (.clk(clk), .resetn(resetn), .fq(fq));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (fq.inst_sram_en) fq.inst_sram_rdata <= fq.inst_sram_addr ^ KEY;
   end

   always @(negedge clk) begin
      #2;
      if (resetn && fq.inst_sram_en) begin
         req_addr.push_back(fq.inst_sram_addr);
         req_cyc.push_back(cyc);
      end
      if (fq.fs_to_ds_valid && fq.ds_allowin) begin
         dlv_bus.push_back(fq.fs_to_ds_bus);
         dlv_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] req_at(input int i);
      if (i < req_addr.size()) return req_addr[i];
      return 'x;
   endfunction

   function automatic logic [70:0] dlv_at(input int i);
      if (i < dlv_bus.size()) return dlv_bus[i];
      return 'x;
   endfunction

   task automatic clear_logs();
      req_addr.delete(); req_cyc.delete(); dlv_bus.delete(); dlv_cyc.delete();
   endtask

   initial begin
      logic [70:0] d;
      logic        found;
      resetn = 1'b0;
      fq.ds_allowin = 1'b0;
      fq.br_bus = '0;
      fq.flush = 1'b0;
      fq.CP0_EPC = '0;
      fq.ws_inst_eret = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_en", 71'(fq.inst_sram_en), 71'(0));
      chk("rst_valid", 71'(fq.fs_to_ds_valid), 71'(0));
      chk("rst_bus", fq.fs_to_ds_bus, 71'(0));

      // Sequential fetch with ID always ready
      @(negedge clk);
      clear_logs();
      resetn = 1'b1;
      fq.ds_allowin = 1'b1;
      repeat (12) @(negedge clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("seq_req%0d", i), 71'(req_at(i)), 71'(32'hbfc00000 + 32'(4 * i)));
      chk("seq_req_back2back", 71'(req_cyc.size() >= 4 ? req_cyc[3] - req_cyc[0] : -1), 71'(3));
      chk("seq_first_latency",
          71'((dlv_cyc.size() > 0 && req_cyc.size() > 0) ? dlv_cyc[0] - req_cyc[0] : -1), 71'(LAT));
      for (int i = 0; i < 3; i++)
         chk($sformatf("seq_dlv_pc%0d", i), 71'(dlv_at(i)[31:0]), 71'(32'hbfc00000 + 32'(4 * i)));
      d = dlv_at(1);
      chk("seq_dlv_inst", 71'(d[63:32]), 71'(32'hbfc00004 ^ KEY));
      chk("seq_dlv_ex", 71'(d[70:64]), 71'(0));

      // Asynchronous reset mid-run, then back-pressure for 10 cycles
      @(negedge clk);
      #2;
      resetn = 1'b0;
      fq.ds_allowin = 1'b0;
      #1;
      chk("async_rst_en", 71'(fq.inst_sram_en), 71'(0));
      chk("async_rst_valid", 71'(fq.fs_to_ds_valid), 71'(0));
      @(negedge clk);
      clear_logs();
      resetn = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("full_req_count", 71'(req_addr.size()), 71'(4));
      chk("full_req_last", 71'(req_at(3)), 71'(32'hbfc0000c));
      chk("full_no_req", 71'(fq.inst_sram_en), 71'(0));
      chk("full_head_pc", 71'({fq.fs_to_ds_valid, fq.fs_to_ds_bus[31:0]}), 71'({1'b1, 32'hbfc00000}));

      // Branch at 0xbfc00010 with the delay slot already queued
      @(negedge clk);
      clear_logs();
      fq.ds_allowin = 1'b1;
      #1;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (fq.fs_to_ds_valid && fq.fs_to_ds_bus[31:0] == 32'hbfc00010) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      chk("br_q_found_branch", 71'(found), 71'(1));
      fq.br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00100};
      @(negedge clk);
      fq.br_bus = {1'b1, 1'b0, 1'b0, 32'h0};
      #1;
      chk("br_q_ds_head", 71'({fq.fs_to_ds_bus[64], fq.fs_to_ds_bus[31:0]}), 71'({1'b1, 32'hbfc00014}));
      @(negedge clk);
      fq.br_bus = '0;
      repeat (6) @(negedge clk);
      begin
         logic [31:0] exp_pc [8];
         exp_pc = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c,
                    32'hbfc00010, 32'hbfc00014, 32'hbfc00100, 32'hbfc00104};
         for (int i = 0; i < 8; i++)
            chk($sformatf("br_q_dlv%0d", i), 71'(dlv_at(i)[31:0]), 71'(exp_pc[i]));
      end
      chk("br_q_bd_ds", 71'(dlv_at(5)[64]), 71'(1));
      chk("br_q_bd_branch", 71'(dlv_at(4)[64]), 71'(0));
      chk("br_q_req_target", 71'(req_at(3)), 71'(32'hbfc00100));

      // Branch with empty queue and nothing inflight (eret to 0xbfc00010, fetch held by br_stall)
      @(negedge clk);
      clear_logs();
      fq.ds_allowin = 1'b0;
      fq.flush = 1'b1; fq.ws_inst_eret = 1'b1; fq.CP0_EPC = 32'hbfc00010;
      fq.br_bus = {1'b0, 1'b1, 1'b0, 32'h0};
      #1;
      chk("bre_flush_req", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00010}));
      @(negedge clk);
      fq.flush = 1'b0; fq.ws_inst_eret = 1'b0;
      #1;
      chk("bre_stall_no_req", 71'(fq.inst_sram_en), 71'(0));
      @(negedge clk);
      fq.ds_allowin = 1'b1;
      fq.br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00100};
      #1;
      chk("bre_branch_head", 71'({fq.fs_to_ds_valid, fq.fs_to_ds_bus[31:0]}), 71'({1'b1, 32'hbfc00010}));
      chk("bre_req_ds", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00014}));
      @(negedge clk);
      fq.br_bus = '0;
      #1;
      chk("bre_req_target", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00100}));
      repeat (4) @(negedge clk);
      chk("bre_dlv0", 71'(dlv_at(0)[31:0]), 71'(32'hbfc00010));
      chk("bre_dlv1", 71'(dlv_at(1)[31:0]), 71'(32'hbfc00014));
      chk("bre_dlv2", 71'(dlv_at(2)[31:0]), 71'(32'hbfc00100));
      chk("bre_dlv2_inst", 71'(dlv_at(2)[63:32]), 71'(32'hbfc00100 ^ KEY));

      // Misaligned branch target -> AdEL entry, HALT, then flush to the exception vector
      @(negedge clk);
      clear_logs();
      fq.ds_allowin = 1'b0;
      fq.flush = 1'b1; fq.ws_inst_eret = 1'b1; fq.CP0_EPC = 32'hbfc00010;
      fq.br_bus = {1'b0, 1'b1, 1'b0, 32'h0};
      @(negedge clk);
      fq.flush = 1'b0; fq.ws_inst_eret = 1'b0;
      @(negedge clk);
      fq.ds_allowin = 1'b1;
      fq.br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00102};
      #1;
      chk("mis_req_ds", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00014}));
      @(negedge clk);
      fq.br_bus = '0;
      #1;
      chk("mis_no_req", 71'(fq.inst_sram_en), 71'(0));
      repeat (6) @(negedge clk);
      #1;
      chk("mis_halt_no_req", 71'(fq.inst_sram_en), 71'(0));
      chk("mis_req_count", 71'(req_addr.size()), 71'(2));
      chk("mis_dlv_count", 71'(dlv_bus.size()), 71'(3));
      chk("mis_dlv_ds", 71'(dlv_at(1)[31:0]), 71'(32'hbfc00014));
      chk("mis_exc_entry", dlv_at(2), {1'b1, 5'h04, 1'b0, 32'h0, 32'hbfc00102});
      @(negedge clk);
      fq.flush = 1'b1;
      #1;
      chk("mis_flush_req", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00380}));
      @(negedge clk);
      fq.flush = 1'b0;
      #1;
      chk("mis_resume_req", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00384}));

      // eret with 3 queued entries plus one response in flight
      @(negedge clk);
      fq.ds_allowin = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      clear_logs();
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("eret_credit_stop", 71'(fq.inst_sram_en), 71'(0));
      chk("eret_pre_req_count", 71'(req_addr.size()), 71'(4));
      fq.flush = 1'b1; fq.ws_inst_eret = 1'b1; fq.CP0_EPC = 32'hbfc00040;
      #1;
      chk("eret_req", 71'({fq.inst_sram_en, fq.inst_sram_addr}), 71'({1'b1, 32'hbfc00040}));
      @(negedge clk);
      fq.flush = 1'b0; fq.ws_inst_eret = 1'b0;
      #1;
`ifdef FS_QUEUE_BYPASS_EN
      chk("eret_after_valid", 71'({fq.fs_to_ds_valid, fq.fs_to_ds_bus[31:0]}), 71'({1'b1, 32'hbfc00040}));
`else
      chk("eret_after_valid", 71'(fq.fs_to_ds_valid), 71'(0));
`endif
      dlv_bus.delete(); dlv_cyc.delete();
      fq.ds_allowin = 1'b1;
      repeat (4) @(negedge clk);
      chk("eret_dlv0", 71'(dlv_at(0)[31:0]), 71'(32'hbfc00040));
      chk("eret_dlv0_inst", 71'(dlv_at(0)[63:32]), 71'(32'hbfc00040 ^ KEY));
      chk("eret_dlv1", 71'(dlv_at(1)[31:0]), 71'(32'hbfc00044));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
